// File: rtl/score_frame_rx.sv
// Frame decoder between the UART byte receiver and the game FSM.
// It assembles SYNC/CMD/DATA/CHK frames and drives the start pulse, the held rival score and error/count outputs.
module score_frame_rx #(
    parameter logic [7:0] SYNC_BYTE = 8'h55,
    parameter logic [7:0] CMD_START = 8'h01,
    parameter logic [7:0] CMD_SCORE = 8'h02,
    parameter int         TIMEOUT   = 50000,
    parameter int         CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] rival_score,
    output logic       start_sig,
    output logic       score_valid,
    output logic       frame_err,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        GOT_SYNC = 2'd1,
        GOT_CMD  = 2'd2,
        GOT_DATA = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state_q;
    logic [7:0]       cmd_q;
    logic [7:0]       data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       rival_score_q;
    logic [7:0]       frame_cnt_q;
    logic             start_sig_q;
    logic             score_valid_q;
    logic             frame_err_q;
    logic             timeout_s;
    logic             chk_ok_s;

    // Incremented idle count, timeout detection and checksum test.
    always_comb begin
        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        // A strobed byte in the same cycle always beats the timeout.
        timeout_s = (state_q != HUNT) && !rx_done && (cnt_d == TIMEOUT_C);
        chk_ok_s  = (rx_data == (cmd_q ^ data_q));
    end

    // Frame FSM, inter-byte timeout counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            cmd_q         <= 8'h00;
            data_q        <= 8'h00;
            cnt_q         <= {CNT_W{1'b0}};
            rival_score_q <= 8'h00;
            frame_cnt_q   <= 8'h00;
            start_sig_q   <= 1'b0;
            score_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            start_sig_q   <= 1'b0;
            score_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;

            if ((state_q == HUNT) || rx_done) begin
                cnt_q <= {CNT_W{1'b0}};
            end else if (timeout_s) begin
                cnt_q       <= {CNT_W{1'b0}};
                state_q     <= HUNT;
                frame_err_q <= 1'b1;
            end else begin
                cnt_q <= cnt_d;
            end

            if (rx_done) begin
                case (state_q)
                    HUNT: begin
                        if (rx_data == SYNC_BYTE) begin
                            state_q <= GOT_SYNC;
                        end else begin
                            state_q <= HUNT;
                        end
                    end
                    GOT_SYNC: begin
                        cmd_q   <= rx_data;
                        state_q <= GOT_CMD;
                    end
                    GOT_CMD: begin
                        data_q  <= rx_data;
                        state_q <= GOT_DATA;
                    end
                    GOT_DATA: begin
                        state_q <= HUNT;
                        if (!chk_ok_s) begin
                            frame_err_q <= 1'b1;
                        end else if (cmd_q == CMD_SCORE) begin
                            rival_score_q <= data_q;
                            score_valid_q <= 1'b1;
                            frame_cnt_q   <= frame_cnt_q + 8'd1;
                        end else if (cmd_q == CMD_START) begin
                            start_sig_q <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                    end
                endcase
            end
        end
    end

    assign rival_score = rival_score_q;
    assign start_sig   = start_sig_q;
    assign score_valid = score_valid_q;
    assign frame_err   = frame_err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_score_frame_rx.sv
// Self-checking bench for score_frame_rx: directed vector table, hand-written corner sequences,
// and randomized frame traffic compared against a queue-based frame model.
module tb_score_frame_rx;

    localparam int TO = 20;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] rival_score;
    logic       start_sig;
    logic       score_valid;
    logic       frame_err;
    logic [7:0] frame_cnt;

    int checks;
    int errors;

    score_frame_rx #(
        .SYNC_BYTE(8'h55),
        .CMD_START(8'h01),
        .CMD_SCORE(8'h02),
        .TIMEOUT  (TO),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .rival_score(rival_score),
        .start_sig  (start_sig),
        .score_valid(score_valid),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bytes of the frame in progress plus the idle gap length.
    logic [7:0] m_q[$];
    int         m_idle;
    logic [7:0] m_score;
    logic [7:0] m_cnt;
    logic       m_start;
    logic       m_sv;
    logic       m_err;

    task automatic model_reset();
        m_q.delete();
        m_idle  = 0;
        m_score = 8'h00;
        m_cnt   = 8'h00;
        m_start = 1'b0;
        m_sv    = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input logic d, input logic [7:0] b);
        m_start = 1'b0;
        m_sv    = 1'b0;
        m_err   = 1'b0;
        if (d) begin
            m_idle = 0;
            if (m_q.size() == 0) begin
                if (b == 8'h55) m_q.push_back(b);
            end else if (m_q.size() < 3) begin
                m_q.push_back(b);
            end else begin
                if (b != (m_q[1] ^ m_q[2])) begin
                    m_err = 1'b1;
                end else if (m_q[1] == 8'h02) begin
                    m_score = m_q[2];
                    m_sv    = 1'b1;
                    m_cnt   = m_cnt + 8'd1;
                end else if (m_q[1] == 8'h01) begin
                    m_start = 1'b1;
                    m_cnt   = m_cnt + 8'd1;
                end else begin
                    m_err = 1'b1;
                end
                m_q.delete();
            end
        end else if (m_q.size() != 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_err = 1'b1;
                m_q.delete();
                m_idle = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".rival_score"}, rival_score, m_score);
        chk({tag, ".start_sig"},   {7'd0, start_sig},   {7'd0, m_start});
        chk({tag, ".score_valid"}, {7'd0, score_valid}, {7'd0, m_sv});
        chk({tag, ".frame_err"},   {7'd0, frame_err},   {7'd0, m_err});
        chk({tag, ".frame_cnt"},   frame_cnt, m_cnt);
    endtask

    // One clock: drive inputs, advance the model across the edge, compare #1 later.
    task automatic cycle(input logic d, input logic [7:0] b, input string tag);
        rx_done = d;
        rx_data = d ? b : 8'($urandom);
        @(posedge clk);
        model_step(d, b);
        #1;
        chk_model(tag);
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        cycle(1'b1, b, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, tag);
    endtask

    typedef struct {
        logic       done;
        logic [7:0] data;
        logic [7:0] score;
        logic       start;
        logic       sv;
        logic       err;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic d, input logic [7:0] b, input logic [7:0] sc,
                       input logic st, input logic sv, input logic er, input logic [7:0] cn);
        vec_t v;
        v.done = d; v.data = b; v.score = sc; v.start = st; v.sv = sv; v.err = er; v.cnt = cn;
        vecs.push_back(v);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        model_reset();

        // Score frame, start frame, bad checksum, junk + unknown cmd, back-to-back, no resync.
        add(1, 8'h55, 8'h00, 0, 0, 0, 8'd0); add(1, 8'h02, 8'h00, 0, 0, 0, 8'd0);
        add(1, 8'h2A, 8'h00, 0, 0, 0, 8'd0); add(1, 8'h28, 8'h2A, 0, 1, 0, 8'd1);
        add(0, 8'h00, 8'h2A, 0, 0, 0, 8'd1);
        add(1, 8'h55, 8'h2A, 0, 0, 0, 8'd1); add(1, 8'h01, 8'h2A, 0, 0, 0, 8'd1);
        add(1, 8'h00, 8'h2A, 0, 0, 0, 8'd1); add(1, 8'h01, 8'h2A, 1, 0, 0, 8'd2);
        add(0, 8'h00, 8'h2A, 0, 0, 0, 8'd2);
        add(1, 8'h55, 8'h2A, 0, 0, 0, 8'd2); add(1, 8'h02, 8'h2A, 0, 0, 0, 8'd2);
        add(1, 8'h2A, 8'h2A, 0, 0, 0, 8'd2); add(1, 8'h29, 8'h2A, 0, 0, 1, 8'd2);
        add(0, 8'h00, 8'h2A, 0, 0, 0, 8'd2);
        add(1, 8'h13, 8'h2A, 0, 0, 0, 8'd2); add(1, 8'h55, 8'h2A, 0, 0, 0, 8'd2);
        add(1, 8'h07, 8'h2A, 0, 0, 0, 8'd2); add(1, 8'h00, 8'h2A, 0, 0, 0, 8'd2);
        add(1, 8'h07, 8'h2A, 0, 0, 1, 8'd2); add(0, 8'h00, 8'h2A, 0, 0, 0, 8'd2);
        add(1, 8'h55, 8'h2A, 0, 0, 0, 8'd2); add(1, 8'h02, 8'h2A, 0, 0, 0, 8'd2);
        add(1, 8'h11, 8'h2A, 0, 0, 0, 8'd2); add(1, 8'h13, 8'h11, 0, 1, 0, 8'd3);
        add(1, 8'h55, 8'h11, 0, 0, 0, 8'd3); add(1, 8'h01, 8'h11, 0, 0, 0, 8'd3);
        add(1, 8'h05, 8'h11, 0, 0, 0, 8'd3); add(1, 8'h04, 8'h11, 1, 0, 0, 8'd4);
        add(1, 8'h55, 8'h11, 0, 0, 0, 8'd4); add(1, 8'h55, 8'h11, 0, 0, 0, 8'd4);
        add(1, 8'h01, 8'h11, 0, 0, 0, 8'd4); add(1, 8'h54, 8'h11, 0, 0, 1, 8'd4);
        add(0, 8'h00, 8'h11, 0, 0, 0, 8'd4);

        repeat (2) @(posedge clk);
        #1;
        chk("reset.rival_score", rival_score, 8'h00);
        chk("reset.frame_cnt", frame_cnt, 8'h00);
        chk("reset.pulses", {5'd0, start_sig, score_valid, frame_err}, 8'h00);
        rst = 1'b0;
        idle(2, "post_reset");

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].done, vecs[i].data, "vec_model");
            chk($sformatf("vec%0d.rival_score", i), rival_score, vecs[i].score);
            chk($sformatf("vec%0d.pulses", i), {5'd0, start_sig, score_valid, frame_err},
                {5'd0, vecs[i].start, vecs[i].sv, vecs[i].err});
            chk($sformatf("vec%0d.frame_cnt", i), frame_cnt, vecs[i].cnt);
        end

        // Timeout: 20 idle cycles after CMD aborts the frame, then a good frame is accepted.
        send(8'h55, "to"); send(8'h02, "to");
        idle(TO - 1, "to_wait");
        chk("to.no_early_err", {7'd0, frame_err}, 8'h00);
        idle(1, "to_fire");
        chk("to.err_pulse", {7'd0, frame_err}, 8'h01);
        idle(1, "to_after");
        chk("to.err_one_cycle", {7'd0, frame_err}, 8'h00);
        send(8'h55, "to2"); send(8'h02, "to2"); send(8'h0F, "to2"); send(8'h0D, "to2");
        chk("to.score_0F", rival_score, 8'h0F);
        chk("to.cnt", frame_cnt, 8'd5);

        // Byte arriving on the cycle the counter would reach TIMEOUT wins.
        send(8'h55, "win"); send(8'h02, "win"); idle(TO - 1, "win");
        send(8'h10, "win"); idle(TO - 1, "win");
        send(8'h12, "win");
        chk("win.score_10", rival_score, 8'h10);
        chk("win.no_err", {7'd0, frame_err}, 8'h00);
        idle(2, "win_idle");

        // Asynchronous reset mid-frame.
        send(8'h55, "mid"); send(8'h02, "mid");
        #2 rst = 1'b1;
        #1;
        chk("midrst.rival_score", rival_score, 8'h00);
        chk("midrst.frame_cnt", frame_cnt, 8'h00);
        chk("midrst.pulses", {5'd0, start_sig, score_valid, frame_err}, 8'h00);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        send(8'h2A, "midrst_drop"); send(8'h28, "midrst_drop");
        idle(3, "midrst_idle");
        chk("midrst.no_err", {7'd0, frame_err}, 8'h00);
        chk("midrst.cnt_still_0", frame_cnt, 8'h00);

        // 256 good frames wrap frame_cnt.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] d;
            d = 8'(i);
            send(8'h55, "wrap"); send(8'h02, "wrap"); send(d, "wrap"); send(8'h02 ^ d, "wrap");
            if (i == 254) chk("wrap.cnt_FF", frame_cnt, 8'hFF);
        end
        chk("wrap.cnt_00", frame_cnt, 8'h00);
        chk("wrap.score_FF", rival_score, 8'hFF);

        // Randomized frames with junk, corruption, odd commands and occasional long gaps.
        for (int f = 0; f < 300; f++) begin
            logic [7:0] fb[4];
            logic [7:0] cmd;
            int         r;
            r = int'($urandom_range(0, 9));
            cmd = (r < 4) ? 8'h02 : (r < 8) ? 8'h01 : 8'($urandom);
            fb[0] = 8'h55;
            fb[1] = cmd;
            fb[2] = 8'($urandom);
            fb[3] = cmd ^ fb[2];
            if ($urandom_range(0, 4) == 0) fb[3] = fb[3] ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) send(8'($urandom), "rand_junk");
            for (int k = 0; k < 4; k++) begin
                int gap;
                gap = ($urandom_range(0, 19) == 0) ? int'($urandom_range(15, 25))
                                                   : int'($urandom_range(0, 3));
                idle(gap, "rand_gap");
                send(fb[k], "rand_byte");
            end
        end
        idle(TO + 2, "final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
